firefly_led: RTL and testbench
==============================

# firefly_led

- Hardware method block for a "firefly" (breathing) LED effect on an 8-bit LED register.
- Exposes two callable methods, each with a req/busy handshake:
  - `firefly_led(a, b)`: plays one software-PWM frame.
  - `firefly_led_test()`: runs an endless triangle-brightness breathing loop.
- Also exposes the LED register as a directly writable port.
- Sits between a CPU/bus-side method caller and a board LED pin (`led_out[0]`).

## Interface
Parameters:
- `PERIOD`, 16: frame length in cycles used by the test loop; also the number of brightness steps.
- `MAX_LEVEL`, 16: peak brightness of the test loop; must be ≤ `PERIOD`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low reset (`reset==0` resets on the next edge).
- `led_in` in 8: data for a direct LED register write.
- `led_we` in 1: direct write enable for `led_in`.
- `led_out` out 8: LED register.
- `firefly_led_a` in 32: on-cycle count (duty).
- `firefly_led_b` in 32: frame length in cycles.
- `firefly_led_req` in 1: start `firefly_led` (level-sampled).
- `firefly_led_busy` out 1: PWM engine running.
- `firefly_led_test_req` in 1: start `firefly_led_test`.
- `firefly_led_test_busy` out 1: test loop running.

## Operation
- **Reset values:** `led_out`=0, both busy=0, engine state IDLE, `i`=0, `level`=0, direction=up.
- **Control FSM states:** IDLE, PWM, TEST.
- **IDLE:**
  - `firefly_led_test_req`=1 → TEST, with `level`=0, direction up, `i`=0.
  - Else `firefly_led_req`=1 → latch `a`, `b`, clear `i`=0, go to PWM.
  - Test has priority when both requests are high.
- **PWM (single call):**
  - Each cycle: `led_out <= {7'b0, (i < a)}` (unsigned 32-bit compare), then `i <= i+1`.
  - When `i == b-1` (or `b==0`), return to IDLE after this cycle.
  - `a ≥ b`: LED on for the whole frame. `a==0`: LED off for the whole frame.
- **TEST:**
  - Endless frames of `PERIOD` cycles, each using `a=level`, `b=PERIOD`, with the same per-cycle rule as PWM.
  - At the end of each frame, `level` steps by ±1.
  - Direction reverses at `MAX_LEVEL` (up→down) and at 0 (down→up).
  - Level sequence: 0, 1, …, 16, 15, …, 1, 0, 1, …; the full breath is 32 frames = 512 cycles (defaults).
  - Never returns to IDLE; only reset exits.
  - `firefly_led_req` is ignored while in TEST or PWM.
- **Direct write:** `led_we`=1 → `led_out <= led_in`. This overrides an engine write in the same cycle; engine writes resume on the next step.
- **Reset mid-operation:** aborts any method immediately. No partial state survives.

## Timing
- Request sampled at edge N in IDLE → busy=1 from edge N onward (visible in cycle N+1).
- First LED update occurs at edge N+1.
- PWM: `firefly_led_busy` high for exactly `max(b,1)` cycles. It falls at the edge that performs the last LED write.
- Back-to-back calls: a new req may be accepted the cycle busy is seen low. Minimum one IDLE cycle between calls.
- TEST: `firefly_led_test_busy` stays 1 from acceptance until reset. `firefly_led_busy` also reads 1 in TEST, since the engine is running.
- `led_out` is registered; there is no combinational path from any input to any output.

## Structure
- **Package `firefly_led_pkg`:**
  - State enum {IDLE, PWM, TEST}.
  - Default `PERIOD`/`MAX_LEVEL` constants.
  - 32-bit counter typedef.
- **Sub-module `firefly_pwm`:**
  - Natural split for the frame engine.
  - Inputs: start, `a`, `b`.
  - Outputs: `led_bit`, `frame_done`, `busy`.
  - Used by both the PWM and TEST paths.
- **Top:** holds the FSM, the level/direction registers and the LED register.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles → `led_out`=0, both busy=0. Release with no requests → outputs stay 0.
- **Single call:** `firefly_led_req` pulse with a=3, b=8 → `led_out[0]`=1,1,1,0,0,0,0,0 on consecutive cycles. Busy high for exactly 8 cycles, then 0.
- **Edge duties:**
  - a=0, b=4 → LED 0 for 4 cycles.
  - a=10, b=4 → LED 1 for 4 cycles.
  - b=0 → busy for 1 cycle, `led_out` = 0.
- **Test loop:** hold `firefly_led_test_req`=1 from reset release → frame k (k=0..16) has `led_out[0]` high for exactly k of 16 cycles. Frame 17 has 15, and the pattern repeats every 512 cycles for 10000 cycles. `test_busy` stays 1 throughout.
- **Override:** during TEST, `led_we`=1 with `led_in`=8'hA5 for one cycle → `led_out`=8'hA5 that cycle. The next cycle shows the engine value with bits 7:1 = 0.
- **Mid-operation reset:** assert `reset`=0 at cycle 5 of a b=8 call → next cycle `led_out`=0 and busy=0. A new req after release starts cleanly with `i`=0.

Source files
------------

// File: rtl/firefly_led_pkg.sv
// Shared types and defaults for the firefly (breathing) LED method block.
package firefly_led_pkg;

    localparam int unsigned CNT_W         = 32;
    localparam int unsigned DEF_PERIOD    = 16;
    localparam int unsigned DEF_MAX_LEVEL = 16;

    typedef logic [CNT_W-1:0] counter_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PWM  = 2'd1,
        ST_TEST = 2'd2
    } state_t;

endpackage

// File: rtl/firefly_pwm.sv
// Software-PWM frame engine: one frame of b cycles, bit high while i < a.
module firefly_pwm
    import firefly_led_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     start,
    input  counter_t a,
    input  counter_t b,
    output logic     led_bit,
    output logic     frame_done,
    output logic     busy
);

    counter_t i_q;
    counter_t a_q;
    counter_t b_q;

    // Current-cycle engine value and last-cycle flag, both from registers only.
    assign led_bit    = (i_q < a_q);
    assign frame_done = busy && ((i_q == (b_q - counter_t'(1))) || (b_q == '0));

    // Frame counter; a start on the last cycle chains straight into a new frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            i_q  <= '0;
            a_q  <= '0;
            b_q  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            i_q  <= '0;
            a_q  <= a;
            b_q  <= b;
            busy <= 1'b1;
        end else if (frame_done) begin
            busy <= 1'b0;
        end else if (busy) begin
            i_q  <= i_q + counter_t'(1);
        end
    end

endmodule

// File: rtl/firefly_led.sv
// Firefly LED method block: single PWM frame call, endless breathing test loop,
// and a direct-write LED register.
module firefly_led
    import firefly_led_pkg::*;
#(
    parameter int unsigned PERIOD    = DEF_PERIOD,
    parameter int unsigned MAX_LEVEL = DEF_MAX_LEVEL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  led_in,
    input  logic        led_we,
    output logic [7:0]  led_out,
    input  logic [31:0] firefly_led_a,
    input  logic [31:0] firefly_led_b,
    input  logic        firefly_led_req,
    output logic        firefly_led_busy,
    input  logic        firefly_led_test_req,
    output logic        firefly_led_test_busy
);

    state_t   state_q, state_d;
    counter_t level_q, level_d;
    logic     down_q, down_d;
    logic     test_busy_q, test_busy_d;
    logic [7:0] led_q, led_d;

    logic     pwm_start;
    counter_t pwm_a;
    counter_t pwm_b;
    logic     pwm_led_bit;
    logic     pwm_frame_done;
    logic     pwm_busy;

    firefly_pwm u_pwm (
        .clk        (clk),
        .reset      (reset),
        .start      (pwm_start),
        .a          (pwm_a),
        .b          (pwm_b),
        .led_bit    (pwm_led_bit),
        .frame_done (pwm_frame_done),
        .busy       (pwm_busy)
    );

    // State, brightness and LED registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            level_q     <= '0;
            down_q      <= 1'b0;
            test_busy_q <= 1'b0;
            led_q       <= '0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            down_q      <= down_d;
            test_busy_q <= test_busy_d;
            led_q       <= led_d;
        end
    end

    // Next-state, level stepping, engine start and LED write selection.
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        down_d      = down_q;
        test_busy_d = test_busy_q;
        led_d       = led_q;
        pwm_start   = 1'b0;
        pwm_a       = '0;
        pwm_b       = counter_t'(PERIOD);

        case (state_q)
            ST_IDLE: begin
                if (firefly_led_test_req) begin
                    state_d     = ST_TEST;
                    level_d     = '0;
                    down_d      = 1'b0;
                    test_busy_d = 1'b1;
                    pwm_start   = 1'b1;
                end else if (firefly_led_req) begin
                    state_d   = ST_PWM;
                    pwm_start = 1'b1;
                    pwm_a     = firefly_led_a;
                    pwm_b     = firefly_led_b;
                end
            end
            ST_PWM: begin
                led_d = {7'b0, pwm_led_bit};
                if (pwm_frame_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_TEST: begin
                led_d = {7'b0, pwm_led_bit};
                if (pwm_frame_done) begin
                    // Triangle: reverse at the peak and at zero.
                    if (!down_q) begin
                        if (level_q >= counter_t'(MAX_LEVEL)) begin
                            level_d = level_q - counter_t'(1);
                            down_d  = 1'b1;
                        end else begin
                            level_d = level_q + counter_t'(1);
                        end
                    end else begin
                        if (level_q == '0) begin
                            level_d = counter_t'(1);
                            down_d  = 1'b0;
                        end else begin
                            level_d = level_q - counter_t'(1);
                        end
                    end
                    pwm_start = 1'b1;
                    pwm_a     = level_d;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Direct write wins over the engine for this cycle only.
        if (led_we) begin
            led_d = led_in;
        end
    end

    assign led_out               = led_q;
    assign firefly_led_busy      = pwm_busy;
    assign firefly_led_test_busy = test_busy_q;

endmodule

// File: tb/tb_firefly_led.sv
// Directed bench for firefly_led: reset, table of single calls, breathing loop,
// direct-write override and mid-call reset.
module tb_firefly_led;

    logic        clk;
    logic        reset;
    logic [7:0]  led_in;
    logic        led_we;
    logic [7:0]  led_out;
    logic [31:0] firefly_led_a;
    logic [31:0] firefly_led_b;
    logic        firefly_led_req;
    logic        firefly_led_busy;
    logic        firefly_led_test_req;
    logic        firefly_led_test_busy;

    int checks;
    int errors;

    firefly_led dut (
        .clk                   (clk),
        .reset                 (reset),
        .led_in                (led_in),
        .led_we                (led_we),
        .led_out               (led_out),
        .firefly_led_a         (firefly_led_a),
        .firefly_led_b         (firefly_led_b),
        .firefly_led_req       (firefly_led_req),
        .firefly_led_busy      (firefly_led_busy),
        .firefly_led_test_req  (firefly_led_test_req),
        .firefly_led_test_busy (firefly_led_test_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          ones;
        int          cycles;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Breathing level of frame f for the default 16/16 configuration.
    function automatic int lvl(input int f);
        int m;
        m = f % 32;
        return (m <= 16) ? m : 32 - m;
    endfunction

    // Expected engine bit after edge N+t of the test loop (t >= 1).
    function automatic logic exp_bit(input int t);
        return ((t - 1) % 16) < lvl((t - 1) / 16);
    endfunction

    task automatic run_call(input logic [31:0] a, input logic [31:0] b,
                            input int ones, input int cycles);
        firefly_led_a   = a;
        firefly_led_b   = b;
        firefly_led_req = 1'b1;
        step();
        firefly_led_req = 1'b0;
        check("call_busy_accept", 32'(firefly_led_busy), 32'd1);
        for (int k = 1; k <= cycles; k++) begin
            step();
            check("call_led", 32'(led_out), (k <= ones) ? 32'd1 : 32'd0);
            check("call_busy", 32'(firefly_led_busy), (k < cycles) ? 32'd1 : 32'd0);
        end
        step();
        check("call_idle_busy", 32'(firefly_led_busy), 32'd0);
    endtask

    initial begin
        int ones;
        logic [7:0] hi_bits;

        checks = 0;
        errors = 0;
        reset                = 1'b0;
        led_in               = 8'h00;
        led_we               = 1'b0;
        firefly_led_a        = '0;
        firefly_led_b        = '0;
        firefly_led_req      = 1'b0;
        firefly_led_test_req = 1'b0;

        vecs[0] = '{a: 32'd3,          b: 32'd8, ones: 3, cycles: 8};
        vecs[1] = '{a: 32'd0,          b: 32'd4, ones: 0, cycles: 4};
        vecs[2] = '{a: 32'd10,         b: 32'd4, ones: 4, cycles: 4};
        vecs[3] = '{a: 32'd0,          b: 32'd0, ones: 0, cycles: 1};
        vecs[4] = '{a: 32'd5,          b: 32'd5, ones: 5, cycles: 5};
        vecs[5] = '{a: 32'd1,          b: 32'd1, ones: 1, cycles: 1};
        vecs[6] = '{a: 32'hFFFF_FFFF,  b: 32'd3, ones: 3, cycles: 3};
        vecs[7] = '{a: 32'd1,          b: 32'd6, ones: 1, cycles: 6};

        // Reset held for three cycles, then released idle.
        step(); step(); step();
        check("rst_led", 32'(led_out), 32'd0);
        check("rst_busy", 32'(firefly_led_busy), 32'd0);
        check("rst_test_busy", 32'(firefly_led_test_busy), 32'd0);
        reset = 1'b1;
        step(); step(); step();
        check("idle_led", 32'(led_out), 32'd0);
        check("idle_busy", 32'(firefly_led_busy), 32'd0);
        check("idle_test_busy", 32'(firefly_led_test_busy), 32'd0);

        // Direct write in IDLE, then hold.
        led_we = 1'b1;
        led_in = 8'h5A;
        step();
        led_we = 1'b0;
        check("we_idle", 32'(led_out), 32'h5A);
        step();
        check("we_hold", 32'(led_out), 32'h5A);

        // Table of single calls, back to back with one idle cycle.
        for (int v = 0; v < 8; v++) begin
            run_call(vecs[v].a, vecs[v].b, vecs[v].ones, vecs[v].cycles);
        end

        // Breathing loop; both requests high so test priority is exercised.
        reset = 1'b0;
        step(); step(); step();
        reset                = 1'b1;
        firefly_led_test_req = 1'b1;
        firefly_led_req      = 1'b1;
        firefly_led_a        = 32'd1;
        firefly_led_b        = 32'd2;
        step();
        check("test_accept_busy", 32'(firefly_led_test_busy), 32'd1);
        check("test_engine_busy", 32'(firefly_led_busy), 32'd1);
        ones    = 0;
        hi_bits = '0;
        for (int t = 1; t <= 10000; t++) begin
            step();
            ones    += int'(led_out[0]);
            hi_bits |= led_out;
            if (t % 16 == 0) begin
                check("frame_ones", 32'(ones), 32'(lvl(t / 16 - 1)));
                check("frame_test_busy", 32'(firefly_led_test_busy), 32'd1);
                check("frame_hi_bits", 32'(hi_bits[7:1]), 32'd0);
                ones    = 0;
                hi_bits = '0;
            end
        end

        // Override during TEST at t=10015, engine value resumes at t=10016.
        for (int t = 10001; t <= 10014; t++) begin
            step();
        end
        check("pre_override", 32'(led_out), 32'(exp_bit(10014)));
        led_we = 1'b1;
        led_in = 8'hA5;
        step();
        led_we = 1'b0;
        check("override", 32'(led_out), 32'hA5);
        step();
        check("post_override", 32'(led_out), 32'(exp_bit(10016)));
        check("post_override_tbusy", 32'(firefly_led_test_busy), 32'd1);

        // Mid-call reset at cycle 5 of a b=8 call.
        firefly_led_test_req = 1'b0;
        firefly_led_req      = 1'b0;
        reset = 1'b0;
        step();
        check("test_exit_tbusy", 32'(firefly_led_test_busy), 32'd0);
        reset = 1'b1;
        step();
        firefly_led_a   = 32'd8;
        firefly_led_b   = 32'd8;
        firefly_led_req = 1'b1;
        step();
        firefly_led_req = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
        end
        check("mid_led_before", 32'(led_out), 32'd1);
        check("mid_busy_before", 32'(firefly_led_busy), 32'd1);
        reset = 1'b0;
        step();
        check("mid_rst_led", 32'(led_out), 32'd0);
        check("mid_rst_busy", 32'(firefly_led_busy), 32'd0);
        reset = 1'b1;
        step();
        run_call(32'd3, 32'd8, 3, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
